fxp_mul_pipe_lanes: RTL and testbench
=====================================

Name: fxp_mul_pipe_lanes

Overview:
Multi-lane, depth-configurable pipelined signed fixed-point multiplier with valid/ready flow control on both sides.
- Each lane multiplies A (Q WIIA.WIFA) by B (Q WIIB.WIFB) and rescales to Q WOI.WOF.
- Rescaling uses selectable rounding and wrap/saturate overflow handling, with per-lane overflow reporting.
- Serves as the shared multiply engine for the GAT datapath: attention coefficient × feature products across LANES parallel channels, carrying a sideband tag for result routing.

Parameters:
- LANES, 4, number of parallel multiply lanes
- WIIA, 12, integer bits of operand A (incl. sign)
- WIFA, 0, fraction bits of operand A
- WIIB, 1, integer bits of operand B (incl. sign)
- WIFB, 31, fraction bits of operand B
- WOI, 8, integer bits of result (incl. sign)
- WOF, 32, fraction bits of result
- ROUND, 1, 1 = round half up on fraction drop; 0 = truncate toward −inf
- SAT, 1, 1 = saturate on integer overflow; 0 = keep low bits (wrap)
- STAGES, 2, pipeline depth in registered stages, legal range 1..8
- TAG_W, 8, sideband tag width

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  pipeline can accept a beat this cycle
- ina  in  LANES*(WIIA+WIFA)  packed A operands; lane k at [k*WA +: WA]
- inb  in  LANES*(WIIB+WIFB)  packed B operands; lane k at [k*WB +: WB]
- in_tag  in  TAG_W  sideband tag, travels with the beat
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts the result
- out  out  LANES*(WOI+WOF)  packed results; lane k at [k*WO +: WO]
- out_tag  out  TAG_W  tag of the presented result
- overflow  out  LANES  per-lane overflow flag of the presented result
- ovf_sticky  out  LANES  per-lane sticky OR of overflow over accepted output beats
- clr_ovf  in  1  clears ovf_sticky

Behaviour:
- Reset: one clock, rstn synchronous active-low; sampled only at the posedge of clk.
  - While rstn=0: all stage valids, out_valid, out, out_tag, overflow and ovf_sticky are 0 at the next edge.
  - in_ready=1 out of reset.
  - Reset mid-operation discards all in-flight beats; no partial output.
- Transfers: a beat transfers on in_valid&in_ready (input side) or out_valid&out_ready (output side).
- Pipeline control:
  - Each stage i holds valid_i, per-lane data and tag.
  - ready_i = ~valid_i | ready_(i+1); ready_(STAGES) = out_ready; in_ready = ready_0.
  - Bubbles collapse; ready chain is combinational; no beat is dropped or duplicated; order is preserved.
- Latency: exactly STAGES cycles from input transfer to out_valid when out_ready is held 1. Throughput is 1 beat/cycle.
- Stage 1 registers the full signed product per lane. Width is WRI=WIIA+WIIB integer bits and WRF=WIFA+WIFB fraction bits; operands are treated as two's complement.
- Rescale:
  - If STAGES≥2, the rescale is registered into the final stage. If STAGES=1, the rescale is combinational from the stage-1 register to out.
  - Fraction, WOF<WRF: drop (WRF−WOF) LSBs. With ROUND=1, add 1 at the highest dropped bit before dropping; a round carry that overflows the integer range counts as overflow.
  - Fraction, WOF≥WRF: zero-pad the LSBs.
  - Integer, WOI<WRI: overflow=1 when the value is not representable. With SAT=1, the result is max positive (0 then all 1s) or min negative (1 then all 0s). With SAT=0, the low WOI+WOF bits are kept.
  - Integer, WOI≥WRI: sign-extend; overflow never asserts.
- Output hold: out, out_tag and overflow stay stable while out_valid&~out_ready.
- ovf_sticky[k]:
  - Set on an output transfer with overflow[k]=1.
  - clr_ovf clears it. If clr_ovf coincides with a setting transfer, the set wins.

Test Plan:
- Defaults, lane0 ina=0x003, inb=0x4000_0000 (0.5), out_ready=1 → after 2 cycles out lane0=0x01_8000_0000 (1.5), overflow=0.
- Defaults, lane1 ina=0xFFF (−1), inb=0x8000_0000 (−1.0) → lane1=0x01_0000_0000 (+1.0), overflow=0.
- Defaults, lane2 ina=0x7FF (2047), inb=0x7FFF_FFFF → overflow[2]=1, lane2=0x7F_FFFF_FFFF, ovf_sticky[2]=1 after transfer. Repeat with SAT=0 → low 40 bits of the rescaled value; clr_ovf clears the sticky bit.
- Rounding, WOF=16: ina=1, inb=0x0000_4000 (2^-17) → ROUND=1 gives out=0x00_0001; ROUND=0 gives 0x00_0000.
- STAGES=3, LANES=2, 6 back-to-back beats with tags 0..5, out_ready=0 for cycles 2–6 → in_ready falls after 3 accepts, resumes on release, outputs tags 0..5 in order with correct products, no loss.
- Reset: assert rstn=0 for 1 cycle with 2 beats in flight → out_valid=0 next cycle, no stale beat ever emitted, in_ready=1.

Source files
------------

// File: rtl/fxp_mul_pipe_lanes.sv
// Multi-lane pipelined signed fixed-point multiplier with valid/ready flow control.
// Stage 1 holds full-precision products; the last stage holds rescaled results.
`timescale 1ns/1ps
module fxp_mul_pipe_lanes #(
  parameter int LANES  = 4,
  parameter int WIIA   = 12,
  parameter int WIFA   = 0,
  parameter int WIIB   = 1,
  parameter int WIFB   = 31,
  parameter int WOI    = 8,
  parameter int WOF    = 32,
  parameter int ROUND  = 1,
  parameter int SAT    = 1,
  parameter int STAGES = 2,
  parameter int TAG_W  = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES*(WIIA+WIFA)-1:0]   ina,
  input  logic [LANES*(WIIB+WIFB)-1:0]   inb,
  input  logic [TAG_W-1:0]               in_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*(WOI+WOF)-1:0]     out,
  output logic [TAG_W-1:0]               out_tag,
  output logic [LANES-1:0]               overflow,
  output logic [LANES-1:0]               ovf_sticky,
  input  logic                           clr_ovf
);

  localparam int WA   = WIIA + WIFA;
  localparam int WB   = WIIB + WIFB;
  localparam int WO   = WOI + WOF;
  localparam int WRF  = WIFA + WIFB;
  localparam int WR   = WA + WB;
  localparam int DROP = (WOF < WRF) ? (WRF - WOF) : 0;
  localparam int PAD  = (WOF >= WRF) ? (WOF - WRF) : 0;
  // One spare integer bit absorbs the rounding carry before the range check.
  localparam int WE   = WR + 1 + PAD;
  localparam int WBIG = ((WE > WO) ? WE : WO) + 1;
  localparam int RSH  = (DROP > 0) ? (DROP - 1) : 0;
  localparam int PS   = (STAGES >= 2) ? (STAGES - 1) : 1;
  localparam logic [WE-1:0] RND = (ROUND != 0 && DROP > 0) ? (WE'(1) << RSH) : '0;

  function automatic logic [WO:0] rescale(input logic [WR-1:0] p);
    logic signed [WE-1:0]   e;
    logic signed [WBIG-1:0] v;
    logic signed [WBIG-1:0] lo;
    logic                   ovf;
    logic [WO-1:0]          r;
    e   = {{(WE-WR){p[WR-1]}}, p};
    e   = e <<< PAD;
    e   = e + signed'(RND);
    e   = e >>> DROP;
    v   = {{(WBIG-WE){e[WE-1]}}, e};
    lo  = {{(WBIG-WO){v[WO-1]}}, v[WO-1:0]};
    ovf = (v != lo);
    if (ovf && SAT != 0)
      r = v[WBIG-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
    else
      r = v[WO-1:0];
    return {ovf, r};
  endfunction

  logic [STAGES:0]      w_ready;
  logic [STAGES-1:0]    r_valid;
  logic [STAGES-1:0]    w_validIn;
  logic [TAG_W-1:0]     r_tag [STAGES];
  logic [TAG_W-1:0]     w_tagIn [STAGES];
  logic [WR-1:0]        r_prod [PS][LANES];
  logic [WR-1:0]        w_prod [LANES];
  logic [LANES*WO-1:0]  w_rescData;
  logic [LANES-1:0]     w_rescOvf;
  logic [LANES-1:0]     r_sticky;

  // A stage can load when it is empty or everything downstream of it can move.
  always_comb begin
    logic rdy;
    rdy = out_ready;
    w_ready[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      rdy = rdy | ~r_valid[s];
      w_ready[s] = rdy;
    end
  end

  always_comb begin
    w_validIn[0] = in_valid;
    w_tagIn[0]   = in_tag;
    for (int s = 1; s < STAGES; s++) begin
      w_validIn[s] = r_valid[s-1];
      w_tagIn[s]   = r_tag[s-1];
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_prod[l] = $signed({{WB{ina[l*WA+WA-1]}}, ina[l*WA +: WA]}) *
                  $signed({{WA{inb[l*WB+WB-1]}}, inb[l*WB +: WB]});
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= '0;
      for (int s = 0; s < STAGES; s++) r_tag[s] <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (w_ready[s]) begin
          r_valid[s] <= w_validIn[s];
          if (w_validIn[s]) r_tag[s] <= w_tagIn[s];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int s = 0; s < PS; s++)
        for (int l = 0; l < LANES; l++) r_prod[s][l] <= '0;
    end else begin
      if (w_ready[0] && in_valid)
        for (int l = 0; l < LANES; l++) r_prod[0][l] <= w_prod[l];
      for (int s = 1; s < PS; s++)
        if (w_ready[s] && r_valid[s-1])
          for (int l = 0; l < LANES; l++) r_prod[s][l] <= r_prod[s-1][l];
    end
  end

  always_comb begin
    w_rescData = '0;
    w_rescOvf  = '0;
    for (int l = 0; l < LANES; l++)
      {w_rescOvf[l], w_rescData[l*WO +: WO]} = rescale(r_prod[PS-1][l]);
  end

  // With a single stage the rescale sits combinationally after the product register.
  if (STAGES >= 2) begin : g_regOut
    logic [LANES*WO-1:0] r_out;
    logic [LANES-1:0]    r_ovf;
    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_out <= '0;
        r_ovf <= '0;
      end else if (w_ready[STAGES-1] && r_valid[STAGES-2]) begin
        r_out <= w_rescData;
        r_ovf <= w_rescOvf;
      end
    end
    assign out      = r_out;
    assign overflow = r_ovf;
  end else begin : g_combOut
    assign out      = w_rescData;
    assign overflow = w_rescOvf;
  end

  // A setting transfer wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rstn) r_sticky <= '0;
    else       r_sticky <= (clr_ovf ? '0 : r_sticky) | ((out_valid && out_ready) ? overflow : '0);
  end

  assign ovf_sticky = r_sticky;
  assign in_ready   = w_ready[0];
  assign out_valid  = r_valid[STAGES-1];
  assign out_tag    = r_tag[STAGES-1];

endmodule

// File: tb/tb_fxp_mul_pipe_lanes.sv
// Randomized scoreboard bench: instance A uses defaults, instance B is a
// 2-lane, 3-stage, Q8.16 wrapping variant with rounding.
`timescale 1ns/1ps
module tb_fxp_mul_pipe_lanes;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic         inValidA = 0, inReadyA, outValidA, outReadyA = 0, clrA = 0;
  logic [47:0]  inaA = '0;
  logic [127:0] inbA = '0;
  logic [7:0]   inTagA = '0, outTagA;
  logic [159:0] outA;
  logic [3:0]   ovfA, stickyA;

  logic         inValidB = 0, inReadyB, outValidB, outReadyB = 0, clrB = 0;
  logic [23:0]  inaB = '0;
  logic [63:0]  inbB = '0;
  logic [7:0]   inTagB = '0, outTagB;
  logic [47:0]  outB;
  logic [1:0]   ovfB, stickyB;

  fxp_mul_pipe_lanes dutA (
    .clk(clk), .rstn(rstn), .in_valid(inValidA), .in_ready(inReadyA),
    .ina(inaA), .inb(inbA), .in_tag(inTagA), .out_valid(outValidA),
    .out_ready(outReadyA), .out(outA), .out_tag(outTagA), .overflow(ovfA),
    .ovf_sticky(stickyA), .clr_ovf(clrA)
  );

  fxp_mul_pipe_lanes #(.LANES(2), .WOF(16), .ROUND(1), .SAT(0), .STAGES(3)) dutB (
    .clk(clk), .rstn(rstn), .in_valid(inValidB), .in_ready(inReadyB),
    .ina(inaB), .inb(inbB), .in_tag(inTagB), .out_valid(outValidB),
    .out_ready(outReadyB), .out(outB), .out_tag(outTagB), .overflow(ovfB),
    .ovf_sticky(stickyB), .clr_ovf(clrB)
  );

  int total = 0;
  int bad = 0;
  int acceptCountB = 0;
  logic [191:0] qA[$];
  logic [191:0] qB[$];

  task automatic checkOutput(input string name, input logic [191:0] got, input logic [191:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Real-valued rescale: product in Q.31, scale to Q8.wof, then range check.
  function automatic logic [64:0] modelLane(input longint a, input longint b, input int wof,
                                           input bit rnd, input bit sat);
    longint p, s, maxV, minV;
    bit o;
    int wo;
    wo = 8 + wof;
    p = a * b;
    if (wof >= 31)  s = p <<< (wof - 31);
    else if (rnd)   s = (p + (longint'(1) <<< (30 - wof))) >>> (31 - wof);
    else            s = p >>> (31 - wof);
    maxV = (longint'(1) <<< (wo - 1)) - 1;
    minV = -(longint'(1) <<< (wo - 1));
    o = (s > maxV) || (s < minV);
    if (o && sat) s = (s > maxV) ? maxV : minV;
    return {o, s};
  endfunction

  function automatic logic [191:0] expectA(input logic [47:0] a, input logic [127:0] b, input logic [7:0] t);
    logic [159:0] d;
    logic [3:0] o;
    logic [64:0] r;
    for (int k = 0; k < 4; k++) begin
      r = modelLane($signed(a[k*12 +: 12]), $signed(b[k*32 +: 32]), 32, 1'b1, 1'b1);
      d[k*40 +: 40] = r[39:0];
      o[k] = r[64];
    end
    return {20'b0, t, o, d};
  endfunction

  function automatic logic [191:0] expectB(input logic [23:0] a, input logic [63:0] b, input logic [7:0] t);
    logic [47:0] d;
    logic [1:0] o;
    logic [64:0] r;
    for (int k = 0; k < 2; k++) begin
      r = modelLane($signed(a[k*12 +: 12]), $signed(b[k*32 +: 32]), 16, 1'b1, 1'b0);
      d[k*24 +: 24] = r[23:0];
      o[k] = r[64];
    end
    return {134'b0, t, o, d};
  endfunction

  function automatic logic [11:0] randOpA();
    if ($urandom_range(0, 1) != 0) return 12'($urandom);
    return 12'(int'($urandom_range(0, 31)) - 16);
  endfunction

  always @(negedge clk) begin
    logic [191:0] e;
    if (!rstn) begin
      qA.delete();
      qB.delete();
    end else begin
      if (outValidA && outReadyA) begin
        if (qA.size() == 0) checkOutput("A spurious beat", outValidA, 0);
        else begin
          e = qA.pop_front();
          checkOutput("A data", outA, e[159:0]);
          checkOutput("A tag/ovf", {outTagA, ovfA}, e[171:160]);
        end
      end
      if (inValidA && inReadyA) qA.push_back(expectA(inaA, inbA, inTagA));
      if (outValidB && outReadyB) begin
        if (qB.size() == 0) checkOutput("B spurious beat", outValidB, 0);
        else begin
          e = qB.pop_front();
          checkOutput("B data", outB, e[47:0]);
          checkOutput("B tag/ovf", {outTagB, ovfB}, e[57:48]);
        end
      end
      if (inValidB && inReadyB) begin
        qB.push_back(expectB(inaB, inbB, inTagB));
        acceptCountB++;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulusA(input logic [47:0] a, input logic [127:0] b, input logic [7:0] t);
    int n;
    logic acc;
    inValidA = 1; inaA = a; inbA = b; inTagA = t;
    n = 0; acc = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = inReadyA;
      cycle();
      n++;
    end
    inValidA = 0;
    checkOutput("A accepted in time", acc, 1);
  endtask

  task automatic applyStimulusB(input logic [23:0] a, input logic [63:0] b, input logic [7:0] t);
    int n;
    logic acc;
    inValidB = 1; inaB = a; inbB = b; inTagB = t;
    n = 0; acc = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = inReadyB;
      cycle();
      n++;
    end
    inValidB = 0;
    checkOutput("B accepted in time", acc, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, base;
    bit doneA, doneB;
    logic [47:0]  dirA;
    logic [127:0] dirB;

    repeat (3) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    checkOutput("reset out_valid A", outValidA, 0);
    checkOutput("reset in_ready A", inReadyA, 1);
    checkOutput("reset out A", outA, 0);
    checkOutput("reset tag/ovf/sticky A", {outTagA, ovfA, stickyA}, 0);
    checkOutput("reset out_valid B", outValidB, 0);
    checkOutput("reset in_ready B", inReadyB, 1);
    cycle();

    // Directed beat: 1.5, +1.0, and two saturating lanes.
    dirA = {12'h800, 12'h7FF, 12'hFFF, 12'h003};
    dirB = {32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h4000_0000};
    outReadyA = 1;
    inValidA = 1; inaA = dirA; inbA = dirB; inTagA = 8'hA5;
    cycle();
    inValidA = 0;
    @(negedge clk);
    checkOutput("A latency 1 cycle", outValidA, 0);
    @(negedge clk);
    checkOutput("A latency 2 cycles", outValidA, 1);
    checkOutput("A lane0 1.5", outA[39:0], 40'h01_8000_0000);
    checkOutput("A lane1 +1.0", outA[79:40], 40'h01_0000_0000);
    checkOutput("A lane2 sat", outA[119:80], 40'h7F_FFFF_FFFF);
    checkOutput("A lane3 sat", outA[159:120], 40'h7F_FFFF_FFFF);
    checkOutput("A overflow", ovfA, 4'b1100);
    checkOutput("A tag", outTagA, 8'hA5);
    cycle();
    @(negedge clk);
    checkOutput("A sticky set", stickyA, 4'b1100);
    cycle();
    clrA = 1; cycle(); clrA = 0;
    @(negedge clk);
    checkOutput("A sticky cleared", stickyA, 4'b0000);
    cycle();

    // Clear coinciding with an overflowing transfer.
    outReadyA = 0;
    applyStimulusA(dirA, dirB, 8'h5A);
    repeat (2) cycle();
    clrA = 1; outReadyA = 1;
    cycle();
    clrA = 0;
    @(negedge clk);
    checkOutput("A sticky set beats clear", stickyA, 4'b1100);
    cycle();
    clrA = 1; cycle(); clrA = 0;

    // Reset with two beats in flight.
    outReadyA = 0;
    applyStimulusA({randOpA(), randOpA(), randOpA(), randOpA()}, {$urandom, $urandom, $urandom, $urandom}, 8'h01);
    applyStimulusA({randOpA(), randOpA(), randOpA(), randOpA()}, {$urandom, $urandom, $urandom, $urandom}, 8'h02);
    rstn = 0;
    cycle();
    rstn = 1;
    @(negedge clk);
    checkOutput("A out_valid after reset", outValidA, 0);
    checkOutput("A in_ready after reset", inReadyA, 1);
    checkOutput("A out after reset", outA, 0);
    outReadyA = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("A no stale beat", outValidA, 0);
    end
    cycle();

    // B rounding: 1 * 2^-17 in Q8.16 rounds half up to one LSB; lane1 wraps.
    outReadyB = 1;
    applyStimulusB({12'h7FF, 12'h001}, {32'h7FFF_FFFF, 32'h0000_4000}, 8'h33);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!outValidB && n < 10);
    checkOutput("B latency", n, 3);
    checkOutput("B round half up", outB[23:0], 24'h000001);
    checkOutput("B overflow wrap lane", ovfB, 2'b10);
    cycle();

    // B back-pressure: six back-to-back beats against a stalled output.
    outReadyB = 0;
    base = acceptCountB;
    fork
      begin
        for (int i = 0; i < 6; i++)
          applyStimulusB({randOpA(), randOpA()}, {$urandom, $urandom}, 8'(i));
      end
      begin
        repeat (12) cycle();
        @(negedge clk);
        checkOutput("B accepts under stall", acceptCountB - base, 3);
        checkOutput("B in_ready under stall", inReadyB, 0);
        cycle();
        outReadyB = 1;
      end
    join

    // Random traffic on both instances with random back-pressure.
    doneA = 0;
    doneB = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 2)) cycle();
          applyStimulusA({randOpA(), randOpA(), randOpA(), randOpA()},
                         {$urandom, $urandom, $urandom, $urandom}, 8'(i));
        end
        doneA = 1;
      end
      begin
        while (!doneA) begin
          outReadyA = ($urandom_range(0, 3) != 0);
          cycle();
        end
        outReadyA = 1;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) cycle();
          applyStimulusB({randOpA(), randOpA()}, {$urandom, $urandom}, 8'(100 + i));
        end
        doneB = 1;
      end
      begin
        while (!doneB) begin
          outReadyB = ($urandom_range(0, 2) != 0);
          cycle();
        end
        outReadyB = 1;
      end
    join

    n = 0;
    while ((qA.size() != 0 || qB.size() != 0) && n < 200) begin
      cycle();
      n++;
    end
    @(negedge clk);
    checkOutput("A drained", qA.size(), 0);
    checkOutput("B drained", qB.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
